conf_loader: RTL and testbench

- Command front-end that loads and inspects the instruction/data memories through their configuration port (conf_sel/conf_rden/conf_wren/conf_addr/conf_wdata/conf_rdata).
- Accepts a byte stream from the host link (UART/network shim) with valid/ready handshake.
- Parses commands into word writes and reads, and returns responses on an outbound byte stream.
- Owns conf_sel, which holds the core in configuring mode until the host issues RUN.

---
 rtl/conf_loader_if.sv | 26 ++
 rtl/conf_loader.sv | 184 ++++++++++++++++++
 tb/tb_conf_loader.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conf_loader_if.sv
// Host byte streams and memory configuration port shared by conf_loader and its neighbours.
// The master side is the loader: it is the rx sink, the tx source and the driver of the conf port.
interface conf_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        conf_sel;
    logic        conf_rden;
    logic        conf_wren;
    logic [31:0] conf_addr;
    logic [31:0] conf_wdata;
    logic [31:0] conf_rdata;

    modport master (
        input  rx_valid, rx_data, tx_ready, conf_rdata,
        output rx_ready, tx_valid, tx_data, conf_sel, conf_rden, conf_wren, conf_addr, conf_wdata
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, conf_rdata,
        input  rx_ready, tx_valid, tx_data, conf_sel, conf_rden, conf_wren, conf_addr, conf_wdata
    );
endinterface

// File: rtl/conf_loader.sv
// Host command parser: turns an inbound byte stream into word writes/reads on the memory
// configuration port, returns responses on the outbound stream and owns conf_sel.
module conf_loader #(
    parameter int unsigned RD_LAT   = 1,
    parameter logic        RST_CONF = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    conf_loader_if.master bus,
    output logic [7:0]    err_cnt
);

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] ADDR    = 4'd1;
    localparam logic [3:0] LEN     = 4'd2;
    localparam logic [3:0] WDATA   = 4'd3;
    localparam logic [3:0] WR      = 4'd4;
    localparam logic [3:0] RD_REQ  = 4'd5;
    localparam logic [3:0] RD_WAIT = 4'd6;
    localparam logic [3:0] RD_SEND = 4'd7;
    localparam logic [3:0] RESP    = 4'd8;

    logic [3:0]  state;
    logic        is_wr;
    logic [1:0]  byte_cnt;
    logic [15:0] count;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  wait_cnt;
    logic        tx_valid_q;
    logic [7:0]  tx_data_q;
    logic        sel_q;
    logic [7:0]  err_q;
    logic        ready_en;

    logic        rx_open;
    logic        accept;
    logic        tx_fire;
    logic [7:0]  err_inc;
    logic [15:0] len_full;

    // ready_en keeps rx_ready low for the first cycle out of reset
    assign rx_open  = (state == IDLE) || (state == ADDR) || (state == LEN) || (state == WDATA);
    assign accept   = bus.rx_valid && bus.rx_ready;
    assign tx_fire  = tx_valid_q && bus.tx_ready;
    assign err_inc  = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
    assign len_full = {count[7:0], bus.rx_data};

    assign bus.rx_ready   = ready_en && rx_open;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.conf_sel   = sel_q;
    assign bus.conf_wren  = (state == WR);
    assign bus.conf_rden  = (state == RD_REQ);
    assign bus.conf_addr  = addr;
    assign bus.conf_wdata = wdata;
    assign err_cnt        = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            is_wr      <= 1'b0;
            byte_cnt   <= '0;
            count      <= '0;
            addr       <= '0;
            wdata      <= '0;
            rdata      <= '0;
            wait_cnt   <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            sel_q      <= RST_CONF;
            err_q      <= '0;
            ready_en   <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            case (state)
                IDLE: if (accept) begin
                    byte_cnt <= '0;
                    case (bus.rx_data)
                        8'h01: begin is_wr <= 1'b1; state <= ADDR; end
                        8'h02: begin is_wr <= 1'b0; state <= ADDR; end
                        8'h03: begin sel_q <= 1'b1; tx_valid_q <= 1'b1; tx_data_q <= 8'h01; state <= RESP; end
                        8'h04: begin sel_q <= 1'b0; tx_valid_q <= 1'b1; tx_data_q <= 8'h01; state <= RESP; end
                        default: begin
                            err_q      <= err_inc;
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= 8'hEE;
                            state      <= RESP;
                        end
                    endcase
                end
                ADDR: if (accept) begin
                    addr     <= {addr[23:0], bus.rx_data};
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) state <= LEN;
                end
                LEN: if (accept) begin
                    count    <= len_full;
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd1) begin
                        byte_cnt <= '0;
                        // In run mode a WRITE payload is still drained so the stream stays framed
                        if (!sel_q) begin
                            err_q <= err_inc;
                            if (is_wr && len_full != 16'd0) begin
                                state <= WDATA;
                            end else begin
                                tx_valid_q <= 1'b1;
                                tx_data_q  <= 8'hE1;
                                state      <= RESP;
                            end
                        end else if (len_full == 16'd0) begin
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= 8'h01;
                            state      <= RESP;
                        end else begin
                            state <= is_wr ? WDATA : RD_REQ;
                        end
                    end
                end
                WDATA: if (accept) begin
                    wdata    <= {bus.rx_data, wdata[31:8]};
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        if (sel_q) begin
                            state <= WR;
                        end else if (count == 16'd1) begin
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= 8'hE1;
                            state      <= RESP;
                        end else begin
                            count <= count - 16'd1;
                        end
                    end
                end
                WR: begin
                    addr  <= addr + 32'd1;
                    count <= count - 16'd1;
                    if (count == 16'd1) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= 8'h01;
                        state      <= RESP;
                    end else begin
                        state <= WDATA;
                    end
                end
                RD_REQ: begin
                    wait_cnt <= '0;
                    state    <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (wait_cnt == 2'(RD_LAT - 1)) begin
                        rdata      <= bus.conf_rdata;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= bus.conf_rdata[7:0];
                        byte_cnt   <= '0;
                        state      <= RD_SEND;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                RD_SEND: if (tx_fire) begin
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        tx_valid_q <= 1'b0;
                        addr       <= addr + 32'd1;
                        count      <= count - 16'd1;
                        state      <= (count == 16'd1) ? IDLE : RD_REQ;
                    end else begin
                        rdata     <= {8'h00, rdata[31:8]};
                        tx_data_q <= rdata[15:8];
                    end
                end
                RESP: if (tx_fire) begin
                    tx_valid_q <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conf_loader.sv
// Bench for conf_loader: directed table, hand sequences and random commands checked against
// a command-level model with its own memory image.
module tb_conf_loader;
    localparam int unsigned RDL = 2;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic [7:0] err_cnt;

    conf_loader_if bus();

    conf_loader #(.RD_LAT(RDL), .RST_CONF(1'b1)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [31:0] ram     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [63:0] wr_q[$];
    logic [7:0]  tx_q[$];
    int          rd_cnt;
    logic        overlap, unstable, prev_stall;
    logic [7:0]  prev_data;
    logic        rd_s_valid;
    logic [31:0] rd_s_data;
    logic        pv[RDL];
    logic [31:0] pd[RDL];
    logic        hold, rand_stall, gaps;
    logic [31:0] wbuf[16];
    int          g;

    logic        m_sel;
    logic [7:0]  m_err;
    logic [31:0] m_addr;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [7:0]  exp_first;
        logic        exp_sel;
        logic [7:0]  exp_err;
    } vec_t;

    vec_t tbl[13];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h3C5A_96E1;
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory side: records writes, serves reads with an RDL-cycle delay line
    always @(negedge clk) begin
        if (!rst_ni) begin
            rd_s_valid = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (bus.conf_wren && bus.conf_rden) overlap = 1'b1;
            if (bus.conf_wren) begin
                wr_q.push_back({bus.conf_addr, bus.conf_wdata});
                ram[bus.conf_addr] = bus.conf_wdata;
            end
            rd_s_valid = bus.conf_rden;
            rd_s_data  = ram_rd(bus.conf_addr);
            if (bus.conf_rden) rd_cnt++;
            if (bus.tx_valid && bus.tx_ready) tx_q.push_back(bus.tx_data);
            if (prev_stall && (!bus.tx_valid || bus.tx_data !== prev_data)) unstable = 1'b1;
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_data  = bus.tx_data;
        end
    end

    always @(posedge clk) begin
        #1;
        for (int k = RDL - 1; k > 0; k--) begin
            pv[k] = pv[k-1];
            pd[k] = pd[k-1];
        end
        pv[0] = rd_s_valid;
        pd[0] = rd_s_data;
        bus.conf_rdata = pv[RDL-1] ? pd[RDL-1] : $urandom();
    end

    always @(posedge clk) begin
        #1;
        if (hold) bus.tx_ready = 1'b0;
        else if (rand_stall) bus.tx_ready = ($urandom_range(0, 2) != 0);
        else bus.tx_ready = 1'b1;
    end

    task automatic wait_cycles(input int k);
        repeat (k) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        logic accepted;
        guard = 0;
        accepted = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (!accepted) begin
            @(negedge clk);
            if (bus.rx_ready) accepted = 1'b1;
            else begin
                guard++;
                if (guard > 200) begin
                    total++;
                    bad++;
                    $display("FAIL rx_accept: byte %0h not taken, rx_ready=%0b expected 1", b, bus.rx_ready);
                    accepted = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom());
        if (gaps) wait_cycles($urandom_range(0, 2));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ctrl"},
              {48'h0, bus.rx_ready, bus.tx_valid, bus.tx_data, bus.conf_sel, bus.conf_rden, bus.conf_wren, err_cnt},
              {48'h0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00});
        check({tag, "_bus"}, {bus.conf_addr, bus.conf_wdata}, 64'h0);
    endtask

    // Command-level model: predicts responses, writes, read bytes, err_cnt, conf_sel, conf_addr
    task automatic run_cmd(input logic [7:0] op, input logic [31:0] addr, input int n);
        logic [7:0]  exp_tx[$];
        logic [63:0] exp_wr[$];
        logic [31:0] a, w;
        int          exp_rd, guard, lim;
        exp_rd = 0;
        case (op)
            8'h03: begin m_sel = 1'b1; exp_tx.push_back(8'h01); end
            8'h04: begin m_sel = 1'b0; exp_tx.push_back(8'h01); end
            8'h01, 8'h02: begin
                m_addr = addr;
                if (!m_sel) begin
                    if (m_err != 8'hFF) m_err = m_err + 8'd1;
                    exp_tx.push_back(8'hE1);
                end else if (n == 0) begin
                    exp_tx.push_back(8'h01);
                end else begin
                    for (int i = 0; i < n; i++) begin
                        a = addr + 32'(i);
                        if (op == 8'h01) begin
                            exp_wr.push_back({a, wbuf[i]});
                            ref_mem[a] = wbuf[i];
                        end else begin
                            w = ref_rd(a);
                            for (int j = 0; j < 4; j++) exp_tx.push_back(w[8*j +: 8]);
                        end
                    end
                    if (op == 8'h01) exp_tx.push_back(8'h01);
                    else exp_rd = n;
                    m_addr = addr + 32'(n);
                end
            end
            default: begin
                if (m_err != 8'hFF) m_err = m_err + 8'd1;
                exp_tx.push_back(8'hEE);
            end
        endcase

        wr_q.delete();
        tx_q.delete();
        rd_cnt = 0;
        send_byte(op);
        if (op == 8'h01 || op == 8'h02) begin
            for (int j = 3; j >= 0; j--) send_byte(addr[8*j +: 8]);
            send_byte(8'(n >> 8));
            send_byte(8'(n));
            if (op == 8'h01)
                for (int i = 0; i < n; i++)
                    for (int j = 0; j < 4; j++) send_byte(wbuf[i][8*j +: 8]);
        end
        guard = 0;
        while (tx_q.size() < exp_tx.size() && guard < 600) begin
            @(posedge clk); #1;
            guard++;
        end
        wait_cycles(4 + RDL);

        check("tx_len", 64'(tx_q.size()), 64'(exp_tx.size()));
        lim = (tx_q.size() < exp_tx.size()) ? tx_q.size() : exp_tx.size();
        for (int i = 0; i < lim; i++) check("tx_byte", 64'(tx_q[i]), 64'(exp_tx[i]));
        check("wr_cnt", 64'(wr_q.size()), 64'(exp_wr.size()));
        lim = (wr_q.size() < exp_wr.size()) ? wr_q.size() : exp_wr.size();
        for (int i = 0; i < lim; i++) check("wr_addr_data", wr_q[i], exp_wr[i]);
        check("rden_cnt", 64'(rd_cnt), 64'(exp_rd));
        check("err_cnt", 64'(err_cnt), 64'(m_err));
        check("conf_sel", 64'(bus.conf_sel), 64'(m_sel));
        check("conf_addr", 64'(bus.conf_addr), 64'(m_addr));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{8'h01, 32'h0000_0010, 2, 32'h1234_5678, 32'hDEAD_BEEF, 8'h01, 1'b1, 8'd0};
        tbl[1]  = '{8'h02, 32'h0000_4000, 1, 32'h0,         32'h0,         8'h0D, 1'b1, 8'd0};
        tbl[2]  = '{8'h04, 32'h0,         0, 32'h0,         32'h0,         8'h01, 1'b0, 8'd0};
        tbl[3]  = '{8'h01, 32'h0000_0030, 1, 32'h1122_3344, 32'h0,         8'hE1, 1'b0, 8'd1};
        tbl[4]  = '{8'h02, 32'h0000_4000, 1, 32'h0,         32'h0,         8'hE1, 1'b0, 8'd2};
        tbl[5]  = '{8'h03, 32'h0,         0, 32'h0,         32'h0,         8'h01, 1'b1, 8'd2};
        tbl[6]  = '{8'h7F, 32'h0,         0, 32'h0,         32'h0,         8'hEE, 1'b1, 8'd3};
        tbl[7]  = '{8'h01, 32'h0000_0020, 1, 32'hAABB_CCDD, 32'h0,         8'h01, 1'b1, 8'd3};
        tbl[8]  = '{8'h01, 32'hFFFF_FFFF, 2, 32'h0102_0304, 32'h0506_0708, 8'h01, 1'b1, 8'd3};
        tbl[9]  = '{8'h02, 32'hFFFF_FFFF, 2, 32'h0,         32'h0,         8'h04, 1'b1, 8'd3};
        tbl[10] = '{8'h01, 32'h0000_0040, 0, 32'h0,         32'h0,         8'h01, 1'b1, 8'd3};
        tbl[11] = '{8'h02, 32'h0000_0040, 0, 32'h0,         32'h0,         8'h01, 1'b1, 8'd3};
        tbl[12] = '{8'h00, 32'h0,         0, 32'h0,         32'h0,         8'hEE, 1'b1, 8'd4};

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b0;
        hold = 1'b0; rand_stall = 1'b0; gaps = 1'b0;
        overlap = 1'b0; unstable = 1'b0; prev_stall = 1'b0; prev_data = 8'h00;
        rd_s_valid = 1'b0; rd_s_data = 32'h0;
        for (int k = 0; k < RDL; k++) begin pv[k] = 1'b0; pd[k] = 32'h0; end
        m_sel = 1'b1; m_err = 8'h00; m_addr = 32'h0;
        ram[32'h4000]     = 32'hCAFE_F00D;
        ref_mem[32'h4000] = 32'hCAFE_F00D;

        rst_ni = 1'b0;
        wait_cycles(3);
        check_reset_values("reset");
        rst_ni = 1'b1;
        wait_cycles(2);

        for (int i = 0; i < 13; i++) begin
            wbuf[0] = tbl[i].w0;
            wbuf[1] = tbl[i].w1;
            run_cmd(tbl[i].op, tbl[i].addr, tbl[i].n);
            check("tbl_first_tx", (tx_q.size() > 0) ? 64'(tx_q[0]) : 64'hFFFF, 64'(tbl[i].exp_first));
            check("tbl_sel", 64'(bus.conf_sel), 64'(tbl[i].exp_sel));
            check("tbl_err", 64'(err_cnt), 64'(tbl[i].exp_err));
        end

        // tx_ready held low for 10 cycles once the first read byte is offered
        unstable = 1'b0;
        fork
            run_cmd(8'h02, 32'h0000_0200, 2);
            begin
                hold = 1'b1;
                g = 0;
                while (!bus.tx_valid && g < 200) begin @(negedge clk); g++; end
                wait_cycles(10);
                hold = 1'b0;
            end
        join
        check("hold_tx_stable", 64'(unstable), 64'h0);
        check("hold_addr_end", 64'(bus.conf_addr), 64'h202);

        rand_stall = 1'b1;
        gaps = 1'b1;
        for (int it = 0; it < 40; it++) begin
            logic [7:0]  op;
            logic [31:0] ad;
            int          r, n;
            r = $urandom_range(0, 9);
            if (r <= 3) op = 8'h01;
            else if (r <= 6) op = 8'h02;
            else if (r == 7) op = 8'h04;
            else if (r == 8) op = 8'h03;
            else op = 8'($urandom_range(5, 255));
            case ($urandom_range(0, 2))
                0: ad = 32'h100 + 32'($urandom_range(0, 15));
                1: ad = 32'hFFFF_FFFE + 32'($urandom_range(0, 3));
                default: ad = 32'h4000 + 32'($urandom_range(0, 3));
            endcase
            n = $urandom_range(0, 3);
            for (int i = 0; i < 4; i++) wbuf[i] = $urandom();
            run_cmd(op, ad, n);
        end

        rand_stall = 1'b0;
        gaps = 1'b0;
        for (int it = 0; it < 260; it++) run_cmd(8'hA5, 32'h0, 0);
        check("err_saturated", 64'(err_cnt), 64'd255);

        // Reset in the middle of a WRITE payload must not leave a partial write behind
        wr_q.delete();
        send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h03); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22);
        rst_ni = 1'b0;
        #1;
        check_reset_values("mid_reset");
        m_sel = 1'b1; m_err = 8'h00; m_addr = 32'h0;
        wait_cycles(2);
        rst_ni = 1'b1;
        wait_cycles(2);
        check("mid_reset_no_write", 64'(wr_q.size()), 64'h0);
        wbuf[0] = 32'h5566_7788;
        run_cmd(8'h01, 32'h0000_0300, 1);

        check("wren_rden_exclusive", 64'(overlap), 64'h0);
        check("tx_stable_global", 64'(unstable), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
